issue_arbiter: RTL and testbench

ISSUE_ARBITER -- requirements
Module: issue_arbiter

---
 rtl/issue_arbiter_pkg.sv | 21 ++
 rtl/issue_arbiter_if.sv | 52 +++++
 rtl/issue_arbiter_rr_pick.sv | 65 ++++++
 rtl/issue_arbiter.sv | 107 ++++++++++
 tb/tb_issue_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/issue_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// issue_arbiter_pkg
// Shared constants for the issue-stage arbiter and the issue-buffer modules
// that feed it.
//   DefDataWidth : default issue-entry instruction width
//   DefPorts     : default number of issue-buffer requesters
//   DefSrcW      : default source-index width, clog2(DefPorts)
//   StallMax     : saturation value of the backpressure counter
// -----------------------------------------------------------------------------
package issue_arbiter_pkg;

  localparam int unsigned DefDataWidth = 47;
  localparam int unsigned DefPorts     = 3;
  localparam int unsigned DefSrcW      = 2;
  localparam int unsigned StallW       = 16;

  localparam logic [StallW-1:0] StallMax = 16'hFFFF;

  typedef logic [StallW-1:0] stall_cnt_t;

endpackage : issue_arbiter_pkg

// File: rtl/issue_arbiter_if.sv
// -----------------------------------------------------------------------------
// issue_arbiter_if
// Bundles the requester side (issue-buffer heads) and the functional-unit side
// of the issue arbiter.
//   req_data  : PORTS*DATA_WIDTH head instructions, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_valid : per-port valid from each issue buffer
//   req_ready : per-port accept back to each issue buffer
//   out_data  : registered instruction to the functional unit
//   out_valid : output-register valid
//   out_ready : functional-unit accept
//   out_src   : port index that out_data came from
// Modports:
//   master : environment (issue buffers + functional unit) driving the arbiter
//   slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface issue_arbiter_if
  import issue_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned PORTS      = DefPorts,
  parameter int unsigned SRC_W      = DefSrcW
) ();

  logic [PORTS*DATA_WIDTH-1:0] req_data;
  logic [PORTS-1:0]            req_valid;
  logic [PORTS-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]       out_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [SRC_W-1:0]            out_src;

  modport master (
    output req_data,
    output req_valid,
    input  req_ready,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_src
  );

  modport slave (
    input  req_data,
    input  req_valid,
    output req_ready,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_src
  );

endinterface : issue_arbiter_if

// File: rtl/issue_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// issue_arbiter_rr_pick  (the rr_pick rotating-priority selector)
// Purely combinational. Picks the first valid port scanning upward from the
// base pointer and wrapping from PORTS-1 back to 0.
//   i_valid     : per-port valid vector
//   i_base      : round-robin base pointer; values >= PORTS are treated as 0
//   o_grant     : one-hot grant (all zeros when nothing is valid)
//   o_grant_idx : index of the granted port (0 when nothing is valid)
//   o_any_valid : at least one port is valid
// -----------------------------------------------------------------------------
module issue_arbiter_rr_pick
  import issue_arbiter_pkg::*;
#(
  parameter int unsigned PORTS = DefPorts,
  parameter int unsigned SRC_W = DefSrcW
) (
  input  logic [PORTS-1:0] i_valid,
  input  logic [SRC_W-1:0] i_base,
  output logic [PORTS-1:0] o_grant,
  output logic [SRC_W-1:0] o_grant_idx,
  output logic             o_any_valid
);

  int unsigned      w_base;
  logic [PORTS-1:0] w_upper_mask;
  logic [PORTS-1:0] w_upper;
  logic [PORTS-1:0] w_cand;
  logic             w_found;

  // Out-of-range pointers cannot occur in normal operation; fold them to 0.
  always_comb begin
    w_base = 32'(i_base);
    if (w_base >= PORTS) begin
      w_base = 0;
    end
  end

  // Ports at or above the base get first pick; if none of them is valid the
  // scan has wrapped, so the lowest valid port overall wins.
  always_comb begin
    w_upper_mask = '0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      w_upper_mask[p] = (p >= w_base);
    end
  end

  assign w_upper     = i_valid & w_upper_mask;
  assign w_cand      = (|w_upper) ? w_upper : i_valid;
  assign o_any_valid = |i_valid;

  // Lowest set bit of the candidate vector.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      if (w_cand[p] && !w_found) begin
        o_grant[p]  = 1'b1;
        o_grant_idx = SRC_W'(p);
        w_found     = 1'b1;
      end
    end
  end

endmodule : issue_arbiter_rr_pick

// File: rtl/issue_arbiter.sv
// -----------------------------------------------------------------------------
// issue_arbiter
// Round-robin arbiter merging PORTS issue-buffer heads into one registered
// functional-unit slot. One output register, one-cycle latency, full
// throughput while the functional unit keeps accepting.
// Ports:
//   clk         : clock, rising-edge
//   rst         : synchronous active-high reset
//   flush       : pipeline flush; empties the output slot, blocks new grants
//   bus         : issue_arbiter_if.slave (requests in, instruction out)
//   stall_count : saturating count of cycles with out_valid=1 and out_ready=0
// -----------------------------------------------------------------------------
module issue_arbiter
  import issue_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned PORTS      = DefPorts,
  parameter int unsigned SRC_W      = DefSrcW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  issue_arbiter_if.slave      bus,
  output logic [StallW-1:0]   stall_count
);

  logic [DATA_WIDTH-1:0] r_out_data;
  logic [SRC_W-1:0]      r_out_src;
  logic                  r_out_valid;
  logic [SRC_W-1:0]      r_rr_ptr;
  stall_cnt_t            r_stall_count;

  logic                  w_load_en;
  logic [PORTS-1:0]      w_grant;
  logic [SRC_W-1:0]      w_grant_idx;
  logic                  w_any_valid;
  logic [SRC_W-1:0]      w_next_ptr;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_stalled;

  // The slot can take a new entry when it is empty or being drained, unless a
  // flush is killing this cycle's traffic.
  assign w_load_en = (!r_out_valid || bus.out_ready) && !flush;

  issue_arbiter_rr_pick #(
    .PORTS (PORTS),
    .SRC_W (SRC_W)
  ) u_rr_pick (
    .i_valid     (bus.req_valid),
    .i_base      (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any_valid (w_any_valid)
  );

  // Grant is already all zeros when nothing is valid.
  assign bus.req_ready = (rst || !w_load_en) ? '0 : w_grant;

  // AND-OR mux over the one-hot grant.
  always_comb begin
    w_sel_data = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      w_sel_data = w_sel_data
                 | ({DATA_WIDTH{w_grant[i]}} & bus.req_data[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  assign w_next_ptr = (w_grant_idx == SRC_W'(PORTS - 1)) ? '0 : w_grant_idx + SRC_W'(1);

  assign w_stalled = r_out_valid && !bus.out_ready;

  // Output slot and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_out_valid <= 1'b0;
      r_rr_ptr    <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_load_en) begin
      if (w_any_valid) begin
        r_out_data  <= w_sel_data;
        r_out_src   <= w_grant_idx;
        r_out_valid <= 1'b1;
        r_rr_ptr    <= w_next_ptr;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Backpressure counter; independent of flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (w_stalled && (r_stall_count != StallMax)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_src   = r_out_src;
  assign bus.out_valid = r_out_valid;
  assign stall_count   = r_stall_count;

endmodule : issue_arbiter

// File: tb/tb_issue_arbiter.sv
// -----------------------------------------------------------------------------
// tb_issue_arbiter
// Directed bench for issue_arbiter with hand-computed expectations.
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// at that point, well before the next edge.
// -----------------------------------------------------------------------------
module tb_issue_arbiter;

  localparam int unsigned DW = 47;
  localparam int unsigned NP = 3;
  localparam int unsigned SW = 2;

  localparam logic [DW-1:0] D0 = 47'h0A0A_0000_1111;
  localparam logic [DW-1:0] D1 = 47'h0B0B_0000_2222;
  localparam logic [DW-1:0] D2 = 47'h0C0C_0000_3333;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [15:0] stall_count;

  int n_checks;
  int n_errors;

  issue_arbiter_if #(
    .DATA_WIDTH (DW),
    .PORTS      (NP),
    .SRC_W      (SW)
  ) bus ();

  issue_arbiter #(
    .DATA_WIDTH (DW),
    .PORTS      (NP),
    .SRC_W      (SW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .bus         (bus),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] port_data(input int p);
    case (p)
      0:       return D0;
      1:       return D1;
      default: return D2;
    endcase
  endfunction

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    flush         = 1'b0;
    bus.req_data  = {D2, D1, D0};
    bus.req_valid = '0;
    bus.out_ready = 1'b0;

    // Reset
    tick();
    tick();
    bus.req_valid = 3'b111;
    bus.out_ready = 1'b1;
    #1;
    check("rst_req_ready", 64'(bus.req_ready), 64'h0);
    tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check("rst_out_src", 64'(bus.out_src), 64'h0);
    check("rst_out_data", 64'(bus.out_data), 64'h0);
    check("rst_stall", 64'(stall_count), 64'h0);
    rst = 1'b0;
    #1;
    check("rel_out_valid", 64'(bus.out_valid), 64'h0);
    check("rel_rr_ptr", 64'(dut.r_rr_ptr), 64'h0);
    check("rel_req_ready", 64'(bus.req_ready), 64'h1);

    // Fairness: 0,1,2,0,1,2 with no bubble
    for (int k = 0; k < 6; k++) begin
      tick();
      check("fair_valid", 64'(bus.out_valid), 64'h1);
      check("fair_src", 64'(bus.out_src), 64'(k % 3));
      check("fair_data", 64'(bus.out_data), 64'(port_data(k % 3)));
      check("fair_ready", 64'(bus.req_ready), 64'(1 << ((k + 1) % 3)));
    end

    // Backpressure: slot holds port 2, pointer back at 0
    bus.out_ready = 1'b0;
    #1;
    check("bp_req_ready0", 64'(bus.req_ready), 64'h0);
    check("bp_stall0", 64'(stall_count), 64'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_data", 64'(bus.out_data), 64'(D2));
      check("bp_src", 64'(bus.out_src), 64'h2);
      check("bp_valid", 64'(bus.out_valid), 64'h1);
      check("bp_req_ready", 64'(bus.req_ready), 64'h0);
    end
    check("bp_stall5", 64'(stall_count), 64'h5);
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(bus.req_ready), 64'h1);
    tick();
    check("bp_reload_src", 64'(bus.out_src), 64'h0);
    check("bp_reload_data", 64'(bus.out_data), 64'(D0));
    check("bp_stall_hold", 64'(stall_count), 64'h5);

    // Wrap/skip: reach rr_ptr=2, then only ports 0,1 valid
    bus.req_valid = 3'b010;
    #1;
    check("wrap_ready1", 64'(bus.req_ready), 64'h2);
    tick();
    check("wrap_src1", 64'(bus.out_src), 64'h1);
    check("wrap_ptr2", 64'(dut.r_rr_ptr), 64'h2);
    bus.req_valid = 3'b011;
    #1;
    check("wrap_ready0", 64'(bus.req_ready), 64'h1);
    tick();
    check("wrap_src0", 64'(bus.out_src), 64'h0);
    check("wrap_data0", 64'(bus.out_data), 64'(D0));
    check("wrap_ptr1", 64'(dut.r_rr_ptr), 64'h1);

    // Flush while the slot is full and all ports request
    bus.req_valid = 3'b111;
    flush         = 1'b1;
    #1;
    check("flush_ready", 64'(bus.req_ready), 64'h0);
    tick();
    check("flush_valid", 64'(bus.out_valid), 64'h0);
    check("flush_ptr", 64'(dut.r_rr_ptr), 64'h1);
    flush = 1'b0;
    #1;
    check("post_flush_ready", 64'(bus.req_ready), 64'h2);

    // Nothing valid: slot empties, pointer holds
    tick();
    check("idle_load_src", 64'(bus.out_src), 64'h1);
    bus.req_valid = 3'b000;
    #1;
    check("idle_ready", 64'(bus.req_ready), 64'h0);
    tick();
    check("idle_valid", 64'(bus.out_valid), 64'h0);
    check("idle_ptr", 64'(dut.r_rr_ptr), 64'h2);
    check("idle_stall", 64'(stall_count), 64'h5);

    // Reset beats flush and a held instruction
    bus.req_valid = 3'b111;
    tick();
    check("pre_rst_src", 64'(bus.out_src), 64'h2);
    bus.out_ready = 1'b0;
    flush         = 1'b1;
    rst           = 1'b1;
    #1;
    check("rst2_ready", 64'(bus.req_ready), 64'h0);
    tick();
    check("rst2_valid", 64'(bus.out_valid), 64'h0);
    check("rst2_src", 64'(bus.out_src), 64'h0);
    check("rst2_data", 64'(bus.out_data), 64'h0);
    check("rst2_ptr", 64'(dut.r_rr_ptr), 64'h0);
    check("rst2_stall", 64'(stall_count), 64'h0);
    rst   = 1'b0;
    flush = 1'b0;

    // Saturation
    bus.req_valid = 3'b001;
    bus.out_ready = 1'b1;
    tick();
    check("sat_load", 64'(bus.out_valid), 64'h1);
    bus.out_ready = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    check("sat_fffe", 64'(stall_count), 64'hFFFE);
    tick();
    check("sat_ffff", 64'(stall_count), 64'hFFFF);
    repeat (4465) @(posedge clk);
    #1;
    check("sat_hold", 64'(stall_count), 64'hFFFF);
    check("sat_data", 64'(bus.out_data), 64'(D0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_issue_arbiter
